load_store_unit: RTL and testbench

- Data-memory access stage sitting between the multicycle control FSM and the data memory.
- The control FSM issues one request per load/store: a byte address taken from ALUOut, store data taken from regB, and funct3.
- The block sequences the word-wide memory, which has no byte enables. It performs sub-word stores as read-modify-write, extracts and extends loaded bytes and halfwords, and flags misaligned or illegal accesses.
- The result feeds the MemData register and write-back mux.

---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request and data-memory bus of the load/store unit.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready; done pulses for one cycle when it retires.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata_out;
    logic              done;
    logic              misaligned;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_write, funct3, addr, wdata, mem_rdata,
        input  req_ready, rdata_out, done, misaligned, mem_addr, mem_wr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, funct3, addr, wdata, mem_rdata,
        output req_ready, rdata_out, done, misaligned, mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory access stage: sequences a word-wide memory without byte enables,
// doing sub-word stores as read-modify-write and extending sub-word loads.
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus,
    output logic [2:0]       stateDbg
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } stateT;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    stateT             state;
    stateT             stateNext;
    logic [2:0]        cnt;
    logic [1:0]        lowAddrQ;
    logic [2:0]        funct3Q;
    logic [15:0]       wdataQ;
    logic              writeQ;
    logic [ADDR_W-1:0] memAddrQ;
    logic [31:0]       memWdataQ;
    logic [31:0]       rdataQ;

    logic              accept;
    logic              reqLegal;
    logic              reqMisal;
    logic              reqErr;
    logic              isSw;
    logic [7:0]        byteLane;
    logic [15:0]       halfLane;
    logic [31:0]       loadWord;
    logic [31:0]       mergedWord;

    assign accept = bus.req_valid && (state == IDLE);
    assign isSw   = bus.req_write && (bus.funct3 == 3'b010);

    always_comb begin
        reqLegal = 1'b0;
        reqMisal = 1'b0;
        if (bus.req_write)
            reqLegal = bus.funct3 inside {3'b000, 3'b001, 3'b010};
        else
            reqLegal = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        if (bus.funct3[1:0] == 2'b01 && bus.addr[0])
            reqMisal = 1'b1;
        if (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00)
            reqMisal = 1'b1;
        reqErr = !reqLegal || reqMisal;
    end

    // Lane selection uses the latched low address bits; the memory word arrives later.
    always_comb begin
        byteLane = bus.mem_rdata[{lowAddrQ, 3'b000} +: 8];
        halfLane = bus.mem_rdata[{lowAddrQ[1], 4'b0000} +: 16];
        loadWord = bus.mem_rdata;
        case (funct3Q)
            3'b000:  loadWord = {{24{byteLane[7]}}, byteLane};
            3'b001:  loadWord = {{16{halfLane[15]}}, halfLane};
            3'b100:  loadWord = {24'd0, byteLane};
            3'b101:  loadWord = {16'd0, halfLane};
            default: loadWord = bus.mem_rdata;
        endcase
        mergedWord = bus.mem_rdata;
        if (funct3Q[0])
            mergedWord[{lowAddrQ[1], 4'b0000} +: 16] = wdataQ;
        else
            mergedWord[{lowAddrQ, 3'b000} +: 8] = wdataQ[7:0];
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reqErr)
                        stateNext = ERR;
                    else if (isSw)
                        stateNext = WRITE;
                    else
                        stateNext = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt == 3'd0)
                    stateNext = writeQ ? WRITE : DONE;
            end
            WRITE:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            ERR:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset kills mem_wr at once.
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.done       = (state == DONE) || (state == ERR);
        bus.misaligned = (state == ERR);
        bus.mem_wr     = (state == WRITE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            lowAddrQ  <= 2'd0;
            funct3Q   <= 3'd0;
            wdataQ    <= 16'd0;
            writeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= 32'd0;
            rdataQ    <= 32'd0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lowAddrQ <= bus.addr[1:0];
                        funct3Q  <= bus.funct3;
                        wdataQ   <= bus.wdata[15:0];
                        writeQ   <= bus.req_write;
                        cnt      <= LAT_INIT;
                        if (!reqErr) begin
                            memAddrQ <= {bus.addr[ADDR_W-1:2], 2'b00};
                            if (isSw)
                                memWdataQ <= bus.wdata;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == 3'd0) begin
                        if (writeQ)
                            memWdataQ <= mergedWord;
                        else
                            rdataQ <= loadWord;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = memAddrQ;
    assign bus.mem_wdata = memWdataQ;
    assign bus.rdata_out = rdataQ;
    assign stateDbg      = state;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a MEM_LAT=1 and a MEM_LAT=3 instance run the same traffic
// against a word-level memory model and an arithmetic reference of the access rules.
module tb_load_store_unit;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    logic loadInit;
    always #5 clk = ~clk;

    logic [1:0]  rv;
    logic        reqWrite;
    logic [2:0]  reqF3;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [2:0]  dbg1, dbg3;

    load_store_unit_if #(.ADDR_W(AW)) if1 ();
    load_store_unit_if #(.ADDR_W(AW)) if3 ();

    load_store_unit #(.ADDR_W(AW), .MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1), .stateDbg(dbg1));
    load_store_unit #(.ADDR_W(AW), .MEM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3), .stateDbg(dbg3));

    assign if1.req_valid = rv[0];
    assign if3.req_valid = rv[1];
    assign if1.req_write = reqWrite;
    assign if3.req_write = reqWrite;
    assign if1.funct3    = reqF3;
    assign if3.funct3    = reqF3;
    assign if1.addr      = reqAddr;
    assign if3.addr      = reqAddr;
    assign if1.wdata     = reqWdata;
    assign if3.wdata     = reqWdata;

    logic [1:0]  readyV, doneV, misV, wrV;
    logic [31:0] rdV [2];
    logic [31:0] maddrV [2];
    logic [31:0] mwdV [2];
    assign readyV    = {if3.req_ready, if1.req_ready};
    assign doneV     = {if3.done, if1.done};
    assign misV      = {if3.misaligned, if1.misaligned};
    assign wrV       = {if3.mem_wr, if1.mem_wr};
    assign rdV[0]    = if1.rdata_out;
    assign rdV[1]    = if3.rdata_out;
    assign maddrV[0] = if1.mem_addr;
    assign maddrV[1] = if3.mem_addr;
    assign mwdV[0]   = if1.mem_wdata;
    assign mwdV[1]   = if3.mem_wdata;

    // ---------------- memory models ----------------
    logic [31:0] memArr [2][256];
    logic [31:0] hist0, hist1;

    function automatic logic [31:0] initWord(int i);
        if (i == 16) return 32'h11223344;
        if (i == 64) return 32'h8081F2F3;
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (loadInit) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 256; i++)
                    memArr[d][i] <= initWord(i);
        end else begin
            if (wrV[0]) memArr[0][maddrV[0][9:2]] <= mwdV[0];
            if (wrV[1]) memArr[1][maddrV[1][9:2]] <= mwdV[1];
        end
    end

    // The slow memory returns the word addressed three cycles earlier.
    always @(posedge clk) begin
        hist0 <= maddrV[1];
        hist1 <= hist0;
    end
    assign if1.mem_rdata = memArr[0][maddrV[0][9:2]];
    assign if3.mem_rdata = memArr[1][hist1[9:2]];

    // ---------------- scoreboard / reference ----------------
    int          nTests = 0;
    int          nFail  = 0;
    logic [31:0] refMem [256];
    logic [31:0] expR [2];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic bit isErr(logic wr, logic [2:0] f3, logic [31:0] a);
        bit legal;
        bit misal;
        legal = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        misal = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
        return !legal || misal;
    endfunction

    function automatic logic [31:0] loadVal(logic [31:0] w, logic [2:0] f3, logic [31:0] a);
        logic [31:0] s;
        s = w >> (8 * a[1:0]);
        case (f3)
            3'd0:    return s[7]  ? ((s & 32'hFF)   | 32'hFFFFFF00) : (s & 32'hFF);
            3'd1:    return s[15] ? ((s & 32'hFFFF) | 32'hFFFF0000) : (s & 32'hFFFF);
            3'd4:    return s & 32'hFF;
            3'd5:    return s & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] storeVal(logic [31:0] old, logic [31:0] wd, logic [2:0] f3, logic [31:0] a);
        logic [31:0] mask;
        mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        mask = mask << (8 * a[1:0]);
        return (old & ~mask) | ((wd << (8 * a[1:0])) & mask);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic doOp(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
        int          lat [2];
        int          wrCnt [2];
        int          wrK [2];
        int          expLat [2];
        logic [31:0] wrA [2];
        logic [31:0] wrD [2];
        logic        misS [2];
        logic [31:0] rdS [2];
        bit          err;
        logic [7:0]  idx;
        logic [31:0] newW;
        err  = isErr(wr, f3, a);
        idx  = a[9:2];
        newW = wr ? storeVal(refMem[idx], wd, f3, a) : refMem[idx];
        for (int d = 0; d < 2; d++) begin
            lat[d] = -1; wrCnt[d] = 0; wrK[d] = -1; wrA[d] = 0; wrD[d] = 0; misS[d] = 0; rdS[d] = 0;
            expLat[d] = (d == 0) ? 1 : 3;
            if (wr && f3 == 3'd2) expLat[d] = 1;
            else if (wr) expLat[d] = expLat[d] + 1;
        end
        @(negedge clk);
        checkVal({tag, "_ready"}, {30'd0, readyV}, 32'd3);
        reqWrite = wr; reqF3 = f3; reqAddr = a; reqWdata = wd; rv = 2'b11;
        @(posedge clk);
        #1 rv = 2'b00;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (wrV[d]) begin
                    wrCnt[d]++; wrK[d] = k; wrA[d] = maddrV[d]; wrD[d] = mwdV[d];
                end
                if (doneV[d] && lat[d] < 0) begin
                    lat[d] = k; misS[d] = misV[d]; rdS[d] = rdV[d];
                end
            end
            if (lat[0] >= 0 && lat[1] >= 0) break;
            @(posedge clk);
        end
        for (int d = 0; d < 2; d++) begin
            checkVal($sformatf("%s_d%0d_done", tag, d), 32'(lat[d] >= 0), 32'd1);
            checkVal($sformatf("%s_d%0d_mis", tag, d), 32'(misS[d]), 32'(err));
            if (!err)
                checkVal($sformatf("%s_d%0d_lat", tag, d), lat[d], expLat[d]);
            if (!err && !wr)
                expR[d] = loadVal(refMem[idx], f3, a);
            checkVal($sformatf("%s_d%0d_rdata", tag, d), rdS[d], expR[d]);
            checkVal($sformatf("%s_d%0d_wrcnt", tag, d), wrCnt[d], 32'(wr && !err));
            if (wr && !err) begin
                checkVal($sformatf("%s_d%0d_wrcyc", tag, d), wrK[d], expLat[d] - 1);
                checkVal($sformatf("%s_d%0d_wraddr", tag, d), wrA[d], {a[31:2], 2'b00});
                checkVal($sformatf("%s_d%0d_wrdata", tag, d), wrD[d], newW);
            end
        end
        if (wr && !err) refMem[idx] = newW;
        for (int d = 0; d < 2; d++)
            checkVal($sformatf("%s_d%0d_mem", tag, d), memArr[d][idx], refMem[idx]);
    endtask

    task automatic resetMid(input bit inWrite, input string tag);
        @(negedge clk);
        reqWrite = 1'b1; reqF3 = 3'd1; reqAddr = 32'h40; reqWdata = 32'h00005555; rv = 2'b10;
        @(posedge clk);
        #1 rv = 2'b00;
        if (!inWrite) begin
            @(negedge clk);
            checkVal({tag, "_pre_wr"}, 32'(wrV[1]), 32'd0);
        end else begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (wrV[1]) break;
            end
            checkVal({tag, "_pre_wr"}, 32'(wrV[1]), 32'd1);
        end
        rst = 1'b1;
        #1;
        checkVal({tag, "_wr_drop"}, 32'(wrV[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expR[0] = 32'd0;
        expR[1] = 32'd0;
        @(negedge clk);
        checkVal({tag, "_ready"}, 32'(readyV[1]), 32'd1);
        checkVal({tag, "_done"}, 32'(doneV[1]), 32'd0);
        checkVal({tag, "_mem"}, memArr[1][8'h10], refMem[8'h10]);
        checkVal({tag, "_rdata"}, rdV[1], expR[1]);
    endtask

    task automatic backToBack();
        int          doneK [$];
        int          acc2;
        logic [31:0] rdFirst;
        acc2    = -1;
        rdFirst = 32'd0;
        @(negedge clk);
        reqWrite = 1'b0; reqF3 = 3'd2; reqAddr = 32'h100; reqWdata = 32'd0; rv = 2'b10;
        @(posedge clk);
        #1 reqF3 = 3'd0; reqAddr = 32'h101;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (doneV[1]) begin
                doneK.push_back(k);
                if (doneK.size() == 1) rdFirst = rdV[1];
            end
            if (readyV[1] && rv[1] && acc2 < 0) acc2 = k + 1;
            @(posedge clk);
            #1;
            if (acc2 == k + 1) rv = 2'b00;
        end
        rv = 2'b00;
        checkVal("b2b_done_count", doneK.size(), 32'd2);
        checkVal("b2b_accept2", acc2, 32'd5);
        if (doneK.size() >= 2) begin
            checkVal("b2b_done1", doneK[0], 32'd3);
            checkVal("b2b_lat2", doneK[1] - acc2, 32'd3);
        end
        checkVal("b2b_rd1", rdFirst, loadVal(refMem[8'h40], 3'd2, 32'h100));
        expR[1] = loadVal(refMem[8'h40], 3'd0, 32'h101);
        checkVal("b2b_rd2", rdV[1], expR[1]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        rst = 1'b1; loadInit = 1'b1; rv = 2'b00;
        reqWrite = 1'b0; reqF3 = 3'd0; reqAddr = 32'd0; reqWdata = 32'd0;
        expR[0] = 32'd0; expR[1] = 32'd0;
        for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkVal($sformatf("rst_d%0d_ready", d), 32'(readyV[d]), 32'd1);
            checkVal($sformatf("rst_d%0d_done", d), 32'(doneV[d]), 32'd0);
            checkVal($sformatf("rst_d%0d_mis", d), 32'(misV[d]), 32'd0);
            checkVal($sformatf("rst_d%0d_wr", d), 32'(wrV[d]), 32'd0);
            checkVal($sformatf("rst_d%0d_maddr", d), maddrV[d], 32'd0);
            checkVal($sformatf("rst_d%0d_mwdata", d), mwdV[d], 32'd0);
            checkVal($sformatf("rst_d%0d_rdata", d), rdV[d], 32'd0);
        end
        rst = 1'b0; loadInit = 1'b0;

        doOp(1'b0, 3'd0, 32'h101, 32'd0, "lb101");
        checkVal("lb101_const", rdV[0], 32'hFFFFFFF2);
        doOp(1'b0, 3'd4, 32'h103, 32'd0, "lbu103");
        checkVal("lbu103_const", rdV[0], 32'h00000080);
        doOp(1'b0, 3'd1, 32'h102, 32'd0, "lh102");
        checkVal("lh102_const", rdV[1], 32'hFFFF8081);
        doOp(1'b0, 3'd5, 32'h100, 32'd0, "lhu100");
        checkVal("lhu100_const", rdV[0], 32'h0000F2F3);
        doOp(1'b0, 3'd2, 32'h100, 32'd0, "lw100");
        checkVal("lw100_const", rdV[1], 32'h8081F2F3);

        doOp(1'b1, 3'd0, 32'h42, 32'h000000AA, "sb42");
        checkVal("sb42_const", memArr[0][8'h10], 32'h11AA3344);
        doOp(1'b1, 3'd1, 32'h40, 32'h0000BEEF, "sh40");
        checkVal("sh40_const", memArr[1][8'h10], 32'h11AABEEF);
        doOp(1'b1, 3'd2, 32'h200, 32'hDEADBEEF, "sw200");
        checkVal("sw200_const", memArr[0][8'h80], 32'hDEADBEEF);

        doOp(1'b0, 3'd2, 32'h102, 32'd0, "err_lw102");
        doOp(1'b1, 3'd1, 32'h103, 32'h1234, "err_sh103");
        doOp(1'b0, 3'd3, 32'h100, 32'd0, "err_f3_011");

        resetMid(1'b0, "rst_rdwait");
        resetMid(1'b1, "rst_write");

        backToBack();

        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                f3 = 3'($urandom_range(0, 7));
            else if (wr)
                f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0)
                a = (f3[1:0] == 2'd2) ? {a[31:2], 2'b00} : {a[31:1], 1'b0};
            doOp(wr, f3, a, $urandom, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
